// File: rtl/eth_rx_multibuf_if.sv
// Receive link and CPU bus strobes for eth_rx_multibuf.
// The tristate data bus stays a plain inout on the block.
interface eth_rx_multibuf_if;
  logic        recv_sck;
  logic        recv_mosi;
  logic        n_recv_ss;
  logic [15:0] a;
  logic        n_oe;
  logic        n_we;
  logic        n_rdy;

  modport master (
    output recv_sck, recv_mosi, n_recv_ss,
    output a, n_oe, n_we,
    input  n_rdy
  );

  modport slave (
    input  recv_sck, recv_mosi, n_recv_ss,
    input  a, n_oe, n_we,
    output n_rdy
  );
endinterface

// File: rtl/eth_rx_multibuf.sv
// Multi-slot Ethernet receive buffer: serial link in,
// ring of frame slots, CPU register/buffer window out.
module eth_rx_multibuf #(
  parameter int          SLOTS      = 2,
  parameter int          SLOT_BYTES = 2048,
  parameter logic [47:0] MAC        = 48'hFEFAF6F2EEEA,
  parameter bit          BCAST_EN   = 1'b1,
  parameter logic [15:0] REG_BASE   = 16'hFB00,
  parameter logic [15:0] BUF_BASE   = 16'hF000
) (
  input  logic             clk,
  input  logic             n_rst,
  eth_rx_multibuf_if.slave bus,
  inout  wire  [7:0]       d
);
  localparam int PW = $clog2(SLOTS);
  localparam int LW = $clog2(SLOT_BYTES);
  localparam logic [PW:0] FULL = (PW+1)'(SLOTS);
  localparam logic [LW:0] LMAX = (LW+1)'(SLOT_BYTES);

  typedef enum logic [2:0] {
    WAIT_IDLE, IDLE, HDR, BODY, DISCARD
  } rx_state_t;

  rx_state_t state, state_n;

  logic [2:0] sck_q;
  logic [2:0] ss_q;
  logic [1:0] mosi_q;
  logic [2:0] bit_cnt;
  logic [6:0] sr;
  logic [7:0] rx_byte;
  logic       sck_rise;
  logic       ss_lvl;
  logic       ss_fall;
  logic       ss_rise;
  logic       byte_stb;

  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [PW:0]   count;
  logic [LW:0]   len;
  logic [LW:0]   slot_len [SLOTS];
  logic [7:0]    mem [SLOTS*SLOT_BYTES];
  logic          overflow;
  logic [7:0]    drop_cnt;
  logic          mac_ok;
  logic          bc_ok;
  logic [7:0]    mac_byte;
  logic          hdr_ok;

  logic commit, drop, set_ovf;
  logic wr_en, len_clr;
  logic ready, pop, clr_ovf, clr_drop;

  logic        oe_q, we_q, n_rdy_r, wr_go;
  logic [15:0] roff, boff;
  logic        hit_reg, hit_buf;
  logic [7:0]  rd, rd_q;
  logic [LW:0] hlen;
  logic [15:0] hlen16;

  // ss resets to "active" so a frame in flight at
  // reset release cannot fake a falling edge later.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      sck_q   <= '0;
      ss_q    <= '0;
      mosi_q  <= '0;
      bit_cnt <= '0;
      sr      <= '0;
    end else begin
      sck_q  <= {sck_q[1:0], bus.recv_sck};
      ss_q   <= {ss_q[1:0], bus.n_recv_ss};
      mosi_q <= {mosi_q[0], bus.recv_mosi};
      if (ss_lvl) begin
        bit_cnt <= '0;
      end else if (sck_rise) begin
        bit_cnt <= bit_cnt + 3'd1;
        sr      <= rx_byte[7:1];
      end
    end
  end

  assign sck_rise = sck_q[1] & ~sck_q[2];
  assign ss_lvl   = ss_q[1];
  assign ss_fall  = ~ss_q[1] & ss_q[2];
  assign ss_rise  = ss_q[1] & ~ss_q[2];
  assign rx_byte  = {mosi_q[1], sr};
  assign byte_stb = sck_rise & ~ss_lvl &
                    (bit_cnt == 3'd7);

  always_comb begin
    mac_byte = MAC[7:0];
    unique case (len[2:0])
      3'd0: mac_byte = MAC[47:40];
      3'd1: mac_byte = MAC[39:32];
      3'd2: mac_byte = MAC[31:24];
      3'd3: mac_byte = MAC[23:16];
      3'd4: mac_byte = MAC[15:8];
      default: mac_byte = MAC[7:0];
    endcase
  end

  assign hdr_ok = (mac_ok & (rx_byte == mac_byte)) |
                  (bc_ok & (rx_byte == 8'hFF));

  always_comb begin
    state_n = state;
    commit  = 1'b0;
    drop    = 1'b0;
    set_ovf = 1'b0;
    wr_en   = 1'b0;
    len_clr = 1'b0;
    unique case (state)
      WAIT_IDLE: if (ss_lvl) state_n = IDLE;
      IDLE: begin
        if (ss_fall) begin
          if (count < FULL) begin
            state_n = HDR;
            len_clr = 1'b1;
          end else begin
            state_n = DISCARD;
            set_ovf = 1'b1;
            drop    = 1'b1;
          end
        end
      end
      HDR: begin
        if (ss_rise) begin
          state_n = IDLE;
          drop    = 1'b1;
        end else if (byte_stb) begin
          wr_en = 1'b1;
          if (!hdr_ok) begin
            state_n = DISCARD;
            drop    = 1'b1;
          end else if (len[2:0] == 3'd5) begin
            state_n = BODY;
          end
        end
      end
      BODY: begin
        if (ss_rise) begin
          state_n = IDLE;
          commit  = 1'b1;
        end else if (byte_stb) begin
          if (len == LMAX) begin
            state_n = DISCARD;
            drop    = 1'b1;
          end else begin
            wr_en = 1'b1;
          end
        end
      end
      DISCARD: if (ss_rise) state_n = IDLE;
      default: state_n = WAIT_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state    <= WAIT_IDLE;
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      len      <= '0;
      overflow <= 1'b0;
      drop_cnt <= '0;
      mac_ok   <= 1'b0;
      bc_ok    <= 1'b0;
      for (int i = 0; i < SLOTS; i++)
        slot_len[i] <= '0;
    end else begin
      state <= state_n;
      if (len_clr) begin
        len    <= '0;
        mac_ok <= 1'b1;
        bc_ok  <= BCAST_EN;
      end else if (wr_en) begin
        len    <= len + (LW+1)'(1);
        mac_ok <= mac_ok & (rx_byte == mac_byte);
        bc_ok  <= bc_ok & (rx_byte == 8'hFF);
      end
      if (commit) begin
        slot_len[tail] <= len;
        tail           <= tail + PW'(1);
      end
      if (pop) head <= head + PW'(1);
      count <= count + (PW+1)'(commit)
                     - (PW+1)'(pop);
      if (set_ovf)      overflow <= 1'b1;
      else if (clr_ovf) overflow <= 1'b0;
      if (clr_drop)
        drop_cnt <= '0;
      else if (drop && drop_cnt != 8'hFF)
        drop_cnt <= drop_cnt + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[{tail, len[LW-1:0]}] <= rx_byte;
  end

  assign roff    = bus.a - REG_BASE;
  assign boff    = bus.a - BUF_BASE;
  assign hit_reg = roff < 16'd8;
  assign hit_buf = boff < 16'(SLOT_BYTES);

  // n_rdy falls one clk after the registered strobe;
  // that same cycle is the single write/latch point.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      oe_q    <= 1'b0;
      we_q    <= 1'b0;
      n_rdy_r <= 1'b1;
      rd_q    <= '0;
    end else begin
      oe_q    <= ~bus.n_oe;
      we_q    <= ~bus.n_we;
      n_rdy_r <= ~(oe_q | we_q);
      if (n_rdy_r & (oe_q | we_q)) rd_q <= rd;
    end
  end

  assign wr_go    = we_q & n_rdy_r;
  assign ready    = count != '0;
  assign pop      = wr_go & hit_reg &
                    (roff[2:0] == 3'd0) &
                    ~d[0] & ready;
  assign clr_ovf  = wr_go & hit_reg &
                    (roff[2:0] == 3'd0) & ~d[1];
  assign clr_drop = wr_go & hit_reg &
                    (roff[2:0] == 3'd4);

  assign hlen   = ready ? slot_len[head] : '0;
  assign hlen16 = 16'(hlen);

  always_comb begin
    rd = '0;
    unique case (1'b1)
      hit_reg && roff[2:0] == 3'd0:
        rd = {4'(count), 2'b00, overflow, ready};
      hit_reg && roff[2:0] == 3'd2:
        rd = hlen16[7:0];
      hit_reg && roff[2:0] == 3'd3:
        rd = hlen16[15:8];
      hit_reg && roff[2:0] == 3'd4:
        rd = drop_cnt;
      hit_buf && ready:
        rd = mem[{head, boff[LW-1:0]}];
      default: rd = '0;
    endcase
  end

  assign bus.n_rdy = n_rdy_r;
  assign d = (~bus.n_oe & (hit_reg | hit_buf)) ?
             (n_rdy_r ? rd : rd_q) : 8'hzz;
endmodule
